// File: rtl/ext_mem_slave_model.sv
// rtl/ext_mem_slave_model.sv - dual-channel fixed-latency byte memory model with side load port
module ext_mem_slave_model #(
    parameter int BASE_ADDR   = 0,
    parameter int MEMSIZE     = 64,
    parameter int ADDR_W      = 10,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            Mout_oe_ram,
    input  logic [1:0]            Mout_we_ram,
    input  logic [2*ADDR_W-1:0]   Mout_addr_ram,
    input  logic [15:0]           Mout_Wdata_ram,
    input  logic [7:0]            Mout_data_ram_size,
    input  logic [15:0]           Sout_Rdata_ram,
    input  logic [1:0]            Sout_DataRdy,
    output logic [15:0]           M_Rdata_ram,
    output logic [1:0]            M_DataRdy,
    input  logic                  ld_en,
    input  logic                  ld_we,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [7:0]            ld_wdata,
    output logic [7:0]            ld_rdata,
    output logic [2:0]            err_flags
);

    localparam int MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
    localparam int CNT_W     = $clog2(MAX_DELAY);
    localparam int IDX_W     = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam int PIPE_N    = READ_DELAY - 1;
    localparam logic [31:0] LO = 32'(BASE_ADDR);
    localparam logic [31:0] HI = 32'(BASE_ADDR + MEMSIZE);

    logic [7:0]       mem [MEMSIZE];
    logic [CNT_W-1:0] cnt [2];
    logic [7:0]       pipe [2][PIPE_N];

    logic [1:0]       hit, rd_req, wr_req, rd_done, wr_done, own_rdy, wr_commit;
    logic [31:0]      a32 [2];
    logic [3:0]       size [2];
    logic [IDX_W-1:0] offs [2];
    logic [7:0]       mask [2];
    logic [7:0]       wr_byte [2];
    logic [7:0]       rd_data [2];
    logic             ld_hit;
    logic [IDX_W-1:0] ld_idx;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            a32[c]     = 32'(Mout_addr_ram[c*ADDR_W +: ADDR_W]);
            hit[c]     = (a32[c] >= LO) && (a32[c] < HI);
            offs[c]    = IDX_W'(a32[c] - LO);
            rd_req[c]  = Mout_oe_ram[c] && hit[c] && !Mout_we_ram[c];
            wr_req[c]  = Mout_we_ram[c] && hit[c] && !Mout_oe_ram[c];
            size[c]    = Mout_data_ram_size[c*4 +: 4];
            // Mask is formed in 9 bits so a size of 8 never overflows the shift.
            mask[c]    = (size[c] >= 4'd8) ? 8'hFF : 8'((9'd1 << size[c]) - 9'd1);
            wr_byte[c] = (Mout_Wdata_ram[c*8 +: 8] & mask[c]) | (mem[offs[c]] & ~mask[c]);
            rd_done[c] = rd_req[c] && (cnt[c] == CNT_W'(READ_DELAY - 1));
            wr_done[c] = wr_req[c] &&
                         ((WRITE_DELAY == 1) || (cnt[c] == CNT_W'(WRITE_DELAY - 1)));
            own_rdy[c] = reset && (rd_done[c] || wr_done[c]);
            // The side port owns the array for the whole cycle it is strobed.
            wr_commit[c] = reset && wr_done[c] && !ld_en;
            rd_data[c]   = (reset && rd_done[c]) ? pipe[c][PIPE_N-1] : 8'h00;
        end
        ld_hit = 32'(ld_addr) < 32'(MEMSIZE);
        ld_idx = ld_addr[IDX_W-1:0];
    end

    assign M_Rdata_ram = {rd_data[1], rd_data[0]} | Sout_Rdata_ram;
    assign M_DataRdy   = own_rdy | Sout_DataRdy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                cnt[c] <= '0;
                for (int s = 0; s < PIPE_N; s++) begin
                    pipe[c][s] <= 8'h00;
                end
            end
            ld_rdata  <= 8'h00;
            err_flags <= 3'b000;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (rd_req[c]) begin
                    cnt[c] <= rd_done[c] ? '0 : cnt[c] + CNT_W'(1);
                end else if (wr_req[c] && (WRITE_DELAY > 1)) begin
                    cnt[c] <= wr_done[c] ? '0 : cnt[c] + CNT_W'(1);
                end else begin
                    cnt[c] <= '0;
                end
                pipe[c][0] <= rd_req[c] ? mem[offs[c]] : 8'h00;
                for (int s = 1; s < PIPE_N; s++) begin
                    pipe[c][s] <= pipe[c][s-1];
                end
            end
            if (ld_en) begin
                ld_rdata <= (ld_hit && !ld_we) ? mem[ld_idx] : 8'h00;
            end
            err_flags <= err_flags | {ld_en && !ld_hit,
                                      ld_en && (|wr_req),
                                      |(Mout_oe_ram & Mout_we_ram)};
        end
    end

    // Storage deliberately has no reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        for (int c = 0; c < 2; c++) begin
            if (wr_commit[c]) begin
                mem[offs[c]] <= wr_byte[c];
            end
        end
        if (reset && ld_en && ld_we && ld_hit) begin
            mem[ld_idx] <= ld_wdata;
        end
    end

endmodule

// File: tb/tb_ext_mem_slave_model.sv
// tb/tb_ext_mem_slave_model.sv - randomized self-checking bench for ext_mem_slave_model
module tb_ext_mem_slave_model;
    localparam int BASE = 16;
    localparam int MSZ  = 64;
    localparam int AW   = 10;

    logic          clock = 1'b0;
    logic          reset_n, reset4_n;
    logic [1:0]    oe, we;
    logic [2*AW-1:0] addr;
    logic [15:0]   wdata;
    logic [7:0]    size;
    logic [15:0]   sout_rdata;
    logic [1:0]    sout_rdy;
    logic [15:0]   m_rdata, m_rdata4;
    logic [1:0]    m_rdy, m_rdy4;
    logic          ld_en, ld_we;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_wdata, ld_rdata, ld_rdata4;
    logic [2:0]    err, err4;

    int checks = 0;
    int failures = 0;
    logic [7:0] mem_m [MSZ];
    logic [2:0] err_m = 3'b000;

    always #5 clock = ~clock;

    ext_mem_slave_model #(.BASE_ADDR(BASE), .MEMSIZE(MSZ), .ADDR_W(AW),
                          .READ_DELAY(2), .WRITE_DELAY(1)) dut (
        .clock(clock), .reset(reset_n),
        .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
        .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
        .Sout_Rdata_ram(sout_rdata), .Sout_DataRdy(sout_rdy),
        .M_Rdata_ram(m_rdata), .M_DataRdy(m_rdy),
        .ld_en(ld_en), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .err_flags(err));

    ext_mem_slave_model #(.BASE_ADDR(BASE), .MEMSIZE(MSZ), .ADDR_W(AW),
                          .READ_DELAY(4), .WRITE_DELAY(1)) dut4 (
        .clock(clock), .reset(reset4_n),
        .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
        .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
        .Sout_Rdata_ram(sout_rdata), .Sout_DataRdy(sout_rdy),
        .M_Rdata_ram(m_rdata4), .M_DataRdy(m_rdy4),
        .ld_en(ld_en), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata4), .err_flags(err4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit hitf(input int a);
        return (a >= BASE) && (a < BASE + MSZ);
    endfunction

    function automatic logic [7:0] merge(input logic [7:0] old, input logic [7:0] d, input int sz);
        int m;
        m = (sz >= 8) ? 255 : (1 << sz) - 1;
        return (d & m[7:0]) | (old & ~m[7:0]);
    endfunction

    task automatic idle();
        oe = 2'b00; we = 2'b00; addr = '0; wdata = '0; size = '0;
        sout_rdata = '0; sout_rdy = '0;
        ld_en = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ld_wr(input int a, input logic [7:0] d);
        ld_en = 1'b1; ld_we = 1'b1; ld_addr = a[AW-1:0]; ld_wdata = d;
        step(); idle();
        if (a < MSZ) mem_m[a] = d; else err_m[2] = 1'b1;
    endtask

    task automatic ld_rd(input int a, input string tag);
        ld_en = 1'b1; ld_we = 1'b0; ld_addr = a[AW-1:0];
        step(); idle();
        check(tag, ld_rdata, (a < MSZ) ? mem_m[a] : 8'h00);
        if (a >= MSZ) err_m[2] = 1'b1;
    endtask

    task automatic ch_wr(input int c, input int a, input logic [7:0] d, input int sz);
        we[c] = 1'b1; addr[c*AW +: AW] = a[AW-1:0];
        wdata[c*8 +: 8] = d; size[c*4 +: 4] = sz[3:0];
        @(negedge clock);
        check("wr_rdy", m_rdy, hitf(a) ? (2'b01 << c) : 2'b00);
        step(); idle();
        if (hitf(a)) mem_m[a-BASE] = merge(mem_m[a-BASE], d, sz);
    endtask

    task automatic dual_wr(input int a0, input int a1, input logic [7:0] d0, input logic [7:0] d1,
                           input int s0, input int s1);
        logic [7:0] n0, n1;
        we = 2'b11; addr = {a1[AW-1:0], a0[AW-1:0]}; wdata = {d1, d0}; size = {s1[3:0], s0[3:0]};
        @(negedge clock);
        check("dual_rdy", m_rdy, {hitf(a1), hitf(a0)});
        step(); idle();
        if (hitf(a0)) n0 = merge(mem_m[a0-BASE], d0, s0);
        if (hitf(a1)) n1 = merge(mem_m[a1-BASE], d1, s1);
        if (hitf(a0)) mem_m[a0-BASE] = n0;
        if (hitf(a1)) mem_m[a1-BASE] = n1;
    endtask

    task automatic ch_rd(input int c, input int a);
        logic [15:0] exp16;
        exp16 = hitf(a) ? (16'(mem_m[a-BASE]) << (8*c)) : 16'h0000;
        oe[c] = 1'b1; addr[c*AW +: AW] = a[AW-1:0];
        @(negedge clock);
        check("rd_rdy_first", m_rdy, 2'b00);
        check("rd_data_first", m_rdata, 16'h0000);
        step();
        @(negedge clock);
        check("rd_rdy", m_rdy, hitf(a) ? (2'b01 << c) : 2'b00);
        check("rd_data", m_rdata, exp16);
        step(); idle();
    endtask

    task automatic miss_merge(input int c, input int a);
        oe[c] = 1'b1; addr[c*AW +: AW] = a[AW-1:0];
        sout_rdata = 16'($urandom); sout_rdy = 2'($urandom);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check("miss_data", m_rdata, sout_rdata);
            check("miss_rdy", m_rdy, sout_rdy);
            step();
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int a, b, old;
        idle();
        reset_n = 1'b1; reset4_n = 1'b1;
        #1 reset_n = 1'b0; reset4_n = 1'b0;
        oe = 2'b01; addr = AW'(BASE + 3);
        sout_rdata = 16'hBEEF; sout_rdy = 2'b10;
        repeat (2) step();
        check("rst_rdata", m_rdata, 16'hBEEF);
        check("rst_rdy", m_rdy, 2'b10);
        check("rst_err", err, 3'b000);
        check("rst_ldr", ld_rdata, 8'h00);
        idle();
        reset_n = 1'b1; reset4_n = 1'b1;
        step();

        for (int i = 0; i < MSZ; i++) ld_wr(i, 8'($urandom));

        ld_wr(5, 8'hA5);
        ch_rd(0, BASE + 5);
        ld_wr(9, 8'hFF);
        ch_wr(1, BASE + 9, 8'h3C, 4);
        ld_rd(9, "size4_readback");
        check("size4_value", mem_m[9], 8'hFC);
        ch_wr(1, BASE + 9, 8'h3C, 8);
        ld_rd(9, "size8_readback");
        dual_wr(BASE + 7, BASE + 7, 8'h11, 8'h22, 8, 8);
        ld_rd(7, "same_off_ch1_wins");
        check("same_off_value", mem_m[7], 8'h22);

        oe[0] = 1'b1; addr[0 +: AW] = AW'(BASE + MSZ);
        sout_rdy = 2'b01; sout_rdata = 16'h0042;
        @(negedge clock);
        check("edge_miss_data", m_rdata, 16'h0042);
        check("edge_miss_rdy", m_rdy, 2'b01);
        step(); idle();

        old = mem_m[20];
        oe[0] = 1'b1; addr[0 +: AW] = AW'(BASE + 20);
        we[1] = 1'b1; addr[AW +: AW] = AW'(BASE + 20);
        wdata[15:8] = ~old[7:0]; size[7:4] = 4'd8;
        @(negedge clock);
        check("rw_wr_rdy", m_rdy, 2'b10);
        step();
        we = 2'b00; mem_m[20] = ~old[7:0];
        @(negedge clock);
        check("rw_rd_rdy", m_rdy, 2'b01);
        check("rw_old_byte", m_rdata[7:0], old[7:0]);
        step(); idle();
        ld_rd(20, "rw_new_byte");

        oe[0] = 1'b1; we[0] = 1'b1; addr[0 +: AW] = AW'(BASE + 11);
        wdata[7:0] = ~mem_m[11]; size[3:0] = 4'd8;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check("oewe_rdy", m_rdy[0], 1'b0);
            step();
        end
        idle(); err_m[0] = 1'b1;
        check("oewe_err", err, err_m);
        ld_rd(11, "oewe_no_write");

        ld_en = 1'b1; ld_we = 1'b1; ld_addr = AW'(30); ld_wdata = 8'h5A;
        we[0] = 1'b1; addr[0 +: AW] = AW'(BASE + 31); wdata[7:0] = ~mem_m[31]; size[3:0] = 4'd8;
        step(); idle();
        mem_m[30] = 8'h5A; err_m[1] = 1'b1;
        check("coll_err", err, err_m);
        ld_rd(30, "coll_ld_wins");
        ld_rd(31, "coll_ch_dropped");

        ld_wr(MSZ + 3, 8'h77);
        ld_rd(MSZ, "ld_oob_read");
        check("ld_oob_err", err, err_m);

        for (int it = 0; it < 300; it++) begin
            a = $urandom_range(BASE - 4, BASE + MSZ + 3);
            b = $urandom_range(0, 1) ? a : $urandom_range(BASE - 4, BASE + MSZ + 3);
            case ($urandom_range(0, 5))
                0: ld_wr($urandom_range(0, MSZ + 7), 8'($urandom));
                1: ld_rd($urandom_range(0, MSZ + 7), "rnd_ld_rd");
                2: ch_wr($urandom_range(0, 1), a, 8'($urandom), $urandom_range(0, 15));
                3: ch_rd($urandom_range(0, 1), a);
                4: dual_wr(a, b, 8'($urandom), 8'($urandom),
                           $urandom_range(0, 15), $urandom_range(0, 15));
                default: miss_merge($urandom_range(0, 1),
                                    $urandom_range(0, 1) ? $urandom_range(0, BASE - 1)
                                                         : $urandom_range(BASE + MSZ, 1023));
            endcase
        end
        check("rnd_err_sticky", err, err_m);
        for (int i = 0; i < MSZ; i += 7) ld_rd(i, "final_readback");

        oe[0] = 1'b1; addr[0 +: AW] = AW'(BASE + 9);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("rd4_rdy", m_rdy4, (k == 3) ? 2'b01 : 2'b00);
            check("rd4_data", m_rdata4[7:0], (k == 3) ? mem_m[9] : 8'h00);
            step();
        end
        idle();
        step();

        oe[0] = 1'b1; addr[0 +: AW] = AW'(BASE + 9);
        step();
        reset4_n = 1'b0; oe = 2'b00;
        sout_rdy = 2'b10; sout_rdata = 16'h1234;
        #1;
        check("rst4_rdy", m_rdy4, 2'b10);
        check("rst4_rdata", m_rdata4, 16'h1234);
        check("rst4_err", err4, 3'b000);
        check("rst4_ldr", ld_rdata4, 8'h00);
        step();
        reset4_n = 1'b1; idle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("rst4_no_rdy", m_rdy4, 2'b00);
            step();
        end
        ld_en = 1'b1; ld_we = 1'b0; ld_addr = AW'(9);
        step(); idle();
        check("rst4_mem_kept", ld_rdata4, mem_m[9]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
